sdram_arbit: RTL and testbench



---
 rtl/sdram_pkg.sv | 25 ++
 rtl/sdram_arbit.sv | 131 +++++++++++++
 tb/tb_sdram_arbit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, arbiter states and bus widths.
package sdram_pkg;

  localparam int ADDR_W = 13;
  localparam int BA_W   = 2;
  localparam int DQ_W   = 16;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AREF      = 4'b0001;
  localparam logic [3:0] CMD_MREG      = 4'b0000;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_READ      = 4'b0101;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ARBIT,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } arb_state_e;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: init owns the bus until init_end, then refresh > write/read (round-robin).
// One NOP cycle in ARBIT separates grants; no preemption of the current owner.
module sdram_arbit
  import sdram_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              init_end,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_sdram_addr,
  input  logic              wr_sdram_en,
  input  logic [DQ_W-1:0]   wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_sdram_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic [DQ_W-1:0]   sdram_rd_data,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DQ_W-1:0]   sdram_dq
);

  arb_state_e        state_q, state_d;
  logic              last_wr_q, last_wr_d;
  logic              aref_en_q, wr_en_q, rd_en_q;
  logic [3:0]        cmd_mux;
  logic [BA_W-1:0]   ba_mux;
  logic [ADDR_W-1:0] addr_mux;

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    case (state_q)
      ST_INIT:  if (init_end) state_d = ST_ARBIT;
      ST_ARBIT: begin
        if (aref_req)              state_d = ST_AREF;
        else if (wr_req && rd_req) state_d = last_wr_q ? ST_READ : ST_WRITE;
        else if (wr_req)           state_d = ST_WRITE;
        else if (rd_req)           state_d = ST_READ;
      end
      ST_AREF:  if (aref_end) state_d = ST_ARBIT;
      ST_WRITE: if (wr_end) begin
        state_d   = ST_ARBIT;
        last_wr_d = 1'b1;
      end
      ST_READ:  if (rd_end) begin
        state_d   = ST_ARBIT;
        last_wr_d = 1'b0;
      end
      default:  state_d = ST_INIT;
    endcase
  end

  // Grants are registered off the next state so they rise together with the state change.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ST_INIT;
      last_wr_q <= 1'b0;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      aref_en_q <= (state_d == ST_AREF);
      wr_en_q   <= (state_d == ST_WRITE);
      rd_en_q   <= (state_d == ST_READ);
    end
  end

  always_comb begin
    cmd_mux  = init_cmd;
    ba_mux   = init_ba;
    addr_mux = init_addr;
    case (state_q)
      ST_ARBIT: begin
        cmd_mux  = CMD_NOP;
        ba_mux   = '1;
        addr_mux = '1;
      end
      ST_AREF: begin
        cmd_mux  = aref_cmd;
        ba_mux   = aref_ba;
        addr_mux = aref_addr;
      end
      ST_WRITE: begin
        cmd_mux  = wr_cmd;
        ba_mux   = wr_ba;
        addr_mux = wr_sdram_addr;
      end
      ST_READ: begin
        cmd_mux  = rd_cmd;
        ba_mux   = rd_ba;
        addr_mux = rd_sdram_addr;
      end
      default: ;
    endcase
  end

  assign aref_en   = aref_en_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign sdram_cke = 1'b1;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;
  assign sdram_ba   = ba_mux;
  assign sdram_addr = addr_mux;

  assign sdram_dq      = (state_q == ST_WRITE && wr_sdram_en) ? wr_sdram_data : {DQ_W{1'bz}};
  assign sdram_rd_data = sdram_dq;

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: vector table, directed DQ/preemption/round-robin sequences, random vs. model.
module tb_sdram_arbit;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [3:0]  init_cmd;
  logic [1:0]  init_ba;
  logic [12:0] init_addr;
  logic        init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic [3:0]  aref_cmd, wr_cmd, rd_cmd;
  logic [1:0]  aref_ba, wr_ba, rd_ba;
  logic [12:0] aref_addr, wr_sdram_addr, rd_sdram_addr;
  logic        wr_sdram_en;
  logic [15:0] wr_sdram_data;
  logic        aref_en, wr_en, rd_en;
  logic [15:0] sdram_rd_data;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  wire  [15:0] sdram_dq;
  logic        tb_drv_en;
  logic [15:0] tb_drv;

  assign sdram_dq = tb_drv_en ? tb_drv : 16'hzzzz;

  always #5 sys_clk = ~sys_clk;

  sdram_arbit dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr), .init_end(init_end),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba),
    .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba),
    .wr_sdram_addr(wr_sdram_addr), .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba),
    .rd_sdram_addr(rd_sdram_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_rd_data(sdram_rd_data),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
    .sdram_addr(sdram_addr), .sdram_dq(sdram_dq)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       rst, ie, ar, ae, wr, we, rr, re;
    logic [2:0] en;   // {aref_en, wr_en, rd_en} after the edge
    logic [3:0] cmd;  // pin command after the edge
  } vec_t;

  vec_t tbl[20];

  // Behavioural reference: who owns the bus, and the log of completed write/read grants.
  localparam int OWN_INIT = -1, OWN_IDLE = 0, OWN_AREF = 1, OWN_WR = 2, OWN_RD = 3;
  int owner;
  int done_log[$];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] pin_cmd();
    return {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
  endfunction

  function automatic logic [2:0] en_now();
    return {aref_en, wr_en, rd_en};
  endfunction

  task automatic set_in(input logic rst, ie, ar, ae, wr, we, rr, re);
    sys_rst = rst; init_end = ie; aref_req = ar; aref_end = ae;
    wr_req = wr; wr_end = we; rd_req = rr; rd_end = re;
  endtask

  task automatic model_step();
    int side;
    if (sys_rst) begin
      owner = OWN_INIT;
      done_log.delete();
    end else if (owner == OWN_INIT) begin
      if (init_end) owner = OWN_IDLE;
    end else if (owner == OWN_IDLE) begin
      if (aref_req) owner = OWN_AREF;
      else if (wr_req || rd_req) begin
        if (wr_req && rd_req)
          side = (done_log.size() > 0 && done_log[$] == OWN_WR) ? OWN_RD : OWN_WR;
        else
          side = wr_req ? OWN_WR : OWN_RD;
        owner = side;
      end
    end else if ((owner == OWN_AREF && aref_end) || (owner == OWN_WR && wr_end) ||
                 (owner == OWN_RD && rd_end)) begin
      if (owner != OWN_AREF) done_log.push_back(owner);
      if (done_log.size() > 4) void'(done_log.pop_front());
      owner = OWN_IDLE;
    end
  endtask

  function automatic logic [18:0] model_pins();
    case (owner)
      OWN_IDLE: return {4'b0111, 2'b11, 13'h1FFF};
      OWN_AREF: return {aref_cmd, aref_ba, aref_addr};
      OWN_WR:   return {wr_cmd, wr_ba, wr_sdram_addr};
      OWN_RD:   return {rd_cmd, rd_ba, rd_sdram_addr};
      default:  return {init_cmd, init_ba, init_addr};
    endcase
  endfunction

  function automatic logic [2:0] model_en();
    return {owner == OWN_AREF, owner == OWN_WR, owner == OWN_RD};
  endfunction

  initial begin
    init_cmd = 4'b0010; init_ba = 2'b00; init_addr = 13'h0400;
    aref_cmd = 4'b0001; aref_ba = 2'b01; aref_addr = 13'h0001;
    wr_cmd   = 4'b0100; wr_ba   = 2'b10; wr_sdram_addr = 13'h0123;
    rd_cmd   = 4'b0101; rd_ba   = 2'b11; rd_sdram_addr = 13'h0ABC;
    wr_sdram_en = 1'b0; wr_sdram_data = 16'h00A5;
    tb_drv_en = 1'b0; tb_drv = 16'h0000;
    set_in(1, 0, 0, 0, 0, 0, 0, 0);

    //           rst ie ar ae wr we rr re   en      cmd
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'b0010};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'b0010};
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'b0010};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'b0010};
    tbl[4]  = '{0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 4'b0111};
    tbl[5]  = '{0, 1, 1, 0, 1, 0, 1, 0, 3'b100, 4'b0001};
    tbl[6]  = '{0, 1, 0, 1, 1, 0, 1, 0, 3'b000, 4'b0111};
    tbl[7]  = '{0, 1, 0, 0, 1, 0, 1, 0, 3'b010, 4'b0100};
    tbl[8]  = '{0, 1, 0, 0, 1, 1, 1, 0, 3'b000, 4'b0111};
    tbl[9]  = '{0, 1, 0, 0, 1, 0, 1, 0, 3'b001, 4'b0101};
    tbl[10] = '{0, 1, 0, 0, 1, 0, 1, 1, 3'b000, 4'b0111};
    tbl[11] = '{0, 1, 0, 0, 1, 0, 1, 0, 3'b010, 4'b0100};
    tbl[12] = '{0, 1, 0, 1, 1, 0, 1, 0, 3'b010, 4'b0100};
    tbl[13] = '{0, 1, 1, 0, 1, 1, 0, 0, 3'b000, 4'b0111};
    tbl[14] = '{0, 0, 1, 0, 1, 0, 1, 0, 3'b100, 4'b0001};
    tbl[15] = '{0, 1, 0, 1, 0, 0, 0, 0, 3'b000, 4'b0111};
    tbl[16] = '{0, 1, 0, 0, 0, 0, 1, 0, 3'b001, 4'b0101};
    tbl[17] = '{1, 1, 0, 0, 0, 0, 1, 0, 3'b000, 4'b0010};
    tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 1, 3'b000, 4'b0010};
    tbl[19] = '{0, 1, 0, 0, 0, 0, 0, 0, 3'b000, 4'b0111};

    wr_sdram_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_in(tbl[i].rst, tbl[i].ie, tbl[i].ar, tbl[i].ae,
             tbl[i].wr, tbl[i].we, tbl[i].rr, tbl[i].re);
      tick();
      chk($sformatf("vec%0d_en", i), 32'(en_now()), 32'(tbl[i].en));
      chk($sformatf("vec%0d_cmd", i), 32'(pin_cmd()), 32'(tbl[i].cmd));
      if (tbl[i].cmd == 4'b0111)
        chk($sformatf("vec%0d_nop_addr", i), {17'd0, sdram_ba, sdram_addr}, {17'd0, 2'b11, 13'h1FFF});
      if (tbl[i].rst)
        chk($sformatf("vec%0d_dq_rel", i), 32'(sdram_dq === 16'h00A5), 32'd0);
    end
    wr_sdram_en = 1'b0;
    chk("cke", 32'(sdram_cke), 32'd1);

    // DQ drive in WRITE, read-back in READ
    set_in(0, 1, 0, 0, 1, 0, 0, 0);
    tick();
    chk("dq_wr_grant", 32'(en_now()), 32'b010);
    wr_req = 0; wr_sdram_en = 1; wr_sdram_data = 16'h00A5;
    #1 chk("dq_drive", 32'(sdram_dq), 32'h00A5);
    wr_sdram_en = 0;
    #1 chk("dq_release", 32'(sdram_dq === 16'h00A5), 32'd0);
    wr_end = 1; tick(); wr_end = 0;
    chk("dq_wr_done", 32'(en_now()), 32'b000);
    rd_req = 1; tick(); rd_req = 0;
    chk("dq_rd_grant", 32'(en_now()), 32'b001);
    tb_drv = 16'h1234; tb_drv_en = 1;
    #1 chk("rd_data", 32'(sdram_rd_data), 32'h1234);
    tb_drv_en = 0;
    rd_end = 1; tick(); rd_end = 0;

    // Refresh arriving mid-write waits for wr_end
    wr_req = 1; tick(); wr_req = 0;
    tick(); tick();
    aref_req = 1;
    tick(); chk("nopre_1", 32'(en_now()), 32'b010);
    tick(); chk("nopre_2", 32'(en_now()), 32'b010);
    wr_end = 1; tick(); wr_end = 0;
    chk("nopre_arbit", 32'(pin_cmd()), 32'b0111);
    chk("nopre_arbit_en", 32'(en_now()), 32'b000);
    tick(); chk("nopre_aref", 32'(en_now()), 32'b100);
    aref_req = 0; aref_end = 1; tick(); aref_end = 0;
    chk("nopre_aref_done", 32'(en_now()), 32'b000);

    // Round-robin from reset: W, R, W, R, W, R with one NOP between grants
    sys_rst = 1; tick(); sys_rst = 0;
    tick();
    wr_req = 1; rd_req = 1;
    for (int g = 0; g < 6; g++) begin
      tick();
      chk($sformatf("rr%0d_grant", g), 32'(en_now()), (g % 2 == 0) ? 32'b010 : 32'b001);
      if (g % 2 == 0) wr_end = 1; else rd_end = 1;
      tick();
      wr_end = 0; rd_end = 0;
      chk($sformatf("rr%0d_nop", g), {en_now(), pin_cmd()}, {3'b000, 4'b0111});
    end
    wr_req = 0; rd_req = 0;

    // Random traffic against the reference model
    sys_rst = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      model_step();
      chk("rnd_en", 32'(en_now()), 32'(model_en()));
      chk("rnd_pins", {13'd0, pin_cmd(), sdram_ba, sdram_addr}, {13'd0, model_pins()});
      if (owner == OWN_WR && wr_sdram_en)
        chk("rnd_dq", 32'(sdram_dq), 32'(wr_sdram_data));
      else
        chk("rnd_dq_rel", 32'(sdram_dq === wr_sdram_data), 32'd0);
      sys_rst  = ($urandom_range(0, 149) == 0);
      init_end = ($urandom_range(0, 15) != 0);
      aref_req = ($urandom_range(0, 7) == 0);
      aref_end = ($urandom_range(0, 2) == 0);
      wr_req   = $urandom_range(0, 1) == 1;
      wr_end   = ($urandom_range(0, 3) == 0);
      rd_req   = $urandom_range(0, 1) == 1;
      rd_end   = ($urandom_range(0, 3) == 0);
      wr_sdram_en   = $urandom_range(0, 1) == 1;
      wr_sdram_data = 16'($urandom) | 16'h0001;
      wr_sdram_addr = 13'($urandom);
      rd_sdram_addr = 13'($urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
